port_bus_responder: RTL

//   Responder end of the 8-bit CPU port bus (port_id/write_strobe/out_port/read_strobe/in_port) driven by picorv32_soc.

---
 rtl/port_bus_responder_pkg.sv | 18 +
 rtl/port_bus_responder_if.sv | 27 ++
 rtl/port_bus_responder_byte_fifo.sv | 44 ++++
 rtl/port_bus_responder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/port_bus_responder_pkg.sv
// Shared definitions for the port bus responder: register offsets within the
// 4-byte window and STATUS bit positions (also consumed by the firmware header
// generator).
package port_bus_responder_pkg;

  localparam logic [1:0] PB_OFF_DATA   = 2'd0;
  localparam logic [1:0] PB_OFF_STATUS = 2'd1;
  localparam logic [1:0] PB_OFF_CTRL   = 2'd2;
  localparam logic [1:0] PB_OFF_IRQEN  = 2'd3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 6;
  localparam int ST_RX_OVF   = 7;

endpackage

// File: rtl/port_bus_responder_if.sv
// CPU port bus plus fabric byte streams seen by the responder.
// slave = responder side, master = CPU/fabric side.
interface port_bus_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       read_strobe;
  logic [7:0] in_port;
  logic [7:0] ctrl;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       irq;

  modport slave (
    input  port_id, write_strobe, out_port, read_strobe, tx_ready, rx_data, rx_valid,
    output in_port, ctrl, tx_data, tx_valid, rx_ready, irq
  );

  modport master (
    output port_id, write_strobe, out_port, read_strobe, tx_ready, rx_data, rx_valid,
    input  in_port, ctrl, tx_data, tx_valid, rx_ready, irq
  );
endinterface

// File: rtl/port_bus_responder_byte_fifo.sv
// Byte FIFO with show-ahead read data. Pointers carry one extra wrap bit.
// A pop on empty is ignored; a push on full only lands when a pop frees the slot.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);

  logic [7:0]  r_mem [2**AW];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_do_rd;
  logic        w_do_wr;

  assign empty   = (r_wptr == r_rptr);
  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);
  assign rd_data = empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];

  // Pointer update; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/port_bus_responder.sv
// Port bus responder: 4-register window (DATA/STATUS/CTRL/IRQEN) bridging CPU
// bytes to fabric through a TX FIFO and fabric bytes to the CPU through an RX FIFO.
// Optional feature macro: PORT_RESP_IRQ_EN (IRQEN register and level irq output).
module port_bus_responder
  import port_bus_responder_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] CTRL_RST  = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  port_bus_if.slave    bus
);

  logic       w_hit;
  logic [1:0] w_off;
  logic       w_wr;
  logic       w_rd;
  logic       w_tx_push;
  logic       w_rx_pop;
  logic       w_tx_empty, w_tx_full;
  logic       w_rx_empty, w_rx_full;
  logic [7:0] w_rx_head;
  logic       w_tx_drop, w_rx_drop;
  logic [7:0] w_status;
  logic [7:0] w_rd_mux;
  logic       r_tx_ovf, r_rx_ovf;
  logic [7:0] r_ctrl;
  logic [7:0] r_in_port;

  assign w_hit     = (bus.port_id[7:2] == BASE_ADDR[7:2]);
  assign w_off     = bus.port_id[1:0];
  assign w_wr      = bus.write_strobe & w_hit;
  assign w_rd      = bus.read_strobe & w_hit;
  assign w_tx_push = w_wr & (w_off == PB_OFF_DATA);
  assign w_rx_pop  = w_rd & (w_off == PB_OFF_DATA);

  // A push at full survives only if the same-cycle pop frees the slot.
  assign w_tx_drop = w_tx_push & w_tx_full & ~bus.tx_ready;
  assign w_rx_drop = bus.rx_valid & w_rx_full & ~w_rx_pop;

  byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_tx_push),
    .wr_data (bus.out_port),
    .rd_en   (bus.tx_ready),
    .rd_data (bus.tx_data),
    .empty   (w_tx_empty),
    .full    (w_tx_full)
  );

  byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.rx_valid),
    .wr_data (bus.rx_data),
    .rd_en   (w_rx_pop),
    .rd_data (w_rx_head),
    .empty   (w_rx_empty),
    .full    (w_rx_full)
  );

  assign bus.tx_valid = ~w_tx_empty;
  assign bus.rx_ready = ~w_rx_full;
  assign bus.ctrl     = r_ctrl;
  assign bus.in_port  = r_in_port;

  // Sticky overflow flags; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_tx_drop) r_tx_ovf <= 1'b1;
      else if (w_wr && w_off == PB_OFF_STATUS && bus.out_port[ST_TX_OVF]) r_tx_ovf <= 1'b0;
      if (w_rx_drop) r_rx_ovf <= 1'b1;
      else if (w_wr && w_off == PB_OFF_STATUS && bus.out_port[ST_RX_OVF]) r_rx_ovf <= 1'b0;
    end
  end

  // CTRL register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ctrl <= CTRL_RST;
    else if (w_wr && w_off == PB_OFF_CTRL) r_ctrl <= bus.out_port;
  end

  // STATUS byte assembly.
  always_comb begin
    w_status = 8'h00;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_OVF]   = r_rx_ovf;
  end

`ifdef PORT_RESP_IRQ_EN
  logic [1:0] r_irqen;
  logic       r_irq;

  // IRQEN register: {tx_empty_en, rx_nonempty_en}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irqen <= 2'b00;
    else if (w_wr && w_off == PB_OFF_IRQEN) r_irqen <= bus.out_port[1:0];
  end

  // Level interrupt, registered one cycle behind its condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else r_irq <= (r_irqen[0] & ~w_rx_empty) | (r_irqen[1] & w_tx_empty);
  end

  assign bus.irq = r_irq;
`else
  assign bus.irq = 1'b0;
`endif

  // Read mux for the current port_id; non-hit and absent registers read 0.
  always_comb begin
    w_rd_mux = 8'h00;
    if (w_hit) begin
      case (w_off)
        PB_OFF_DATA:   w_rd_mux = w_rx_head;
        PB_OFF_STATUS: w_rd_mux = w_status;
        PB_OFF_CTRL:   w_rd_mux = r_ctrl;
`ifdef PORT_RESP_IRQ_EN
        PB_OFF_IRQEN:  w_rd_mux = {6'b0, r_irqen};
`endif
        default:       w_rd_mux = 8'h00;
      endcase
    end
  end

  // in_port is refreshed every cycle from the read mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_in_port <= 8'h00;
    else r_in_port <= w_rd_mux;
  end

endmodule
